reg_bank_tx: RTL
================

Name: reg_bank_tx

Overview:
- Read-out side of the 4-entry 8-bit switch-loaded register bank used on the board.
- On a start request, walks addresses 0..NUM_REGS-1 through the bank's combinational read mux.
- Serialises each byte onto a single UART-style line: 1 start bit, data LSB-first, 1 stop bit.
- Drives a status/LED view of the byte in flight; lets the bank contents be dumped to a host or scope.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (115200 baud at 50 MHz); must be >= 2.
- NUM_REGS, 4, number of bank entries transmitted per request.
- ADDR_W, 2, width of rd_addr; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 8, width of each bank entry.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  request a full bank dump; sampled only in IDLE.
- rd_addr  out  ADDR_W  address to the bank read mux.
- rd_data  in  DATA_W  bank read data; combinational from rd_addr, valid in the same cycle.
- tx  out  1  serial line; idle level 1.
- busy  out  1  high from the first cycle after start is accepted until the final stop bit ends.
- done  out  1  one-cycle pulse after the last frame completes.
- cur_byte  out  DATA_W  byte currently being shifted, for LED display.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx=1, busy=0, done=0, rd_addr=0, cur_byte=0, shift register=0, bit and clock counters=0.
- Reset asserted mid-frame forces tx=1 immediately, with no clock edge required.
- All outputs are registered.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - On the edge where start=1: go to LOAD, set busy=1, set rd_addr=0.
  - start held high over several cycles is treated as a single request.
- LOAD (exactly 1 cycle):
  - At the exiting edge, capture rd_data into the shift register and cur_byte, set tx=0, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - DATA_W bits, each driven for CLKS_PER_BIT cycles, LSB first; shift right at each bit boundary.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the end, if rd_addr==NUM_REGS-1: go to IDLE, set busy=0, pulse done for exactly 1 cycle.
  - Otherwise: increment rd_addr and go to LOAD. tx stays 1 through LOAD, so the stop bit is extended by 1 cycle between frames.
- Timing (start sampled at edge E0):
  - Each frame takes 1 + (DATA_W+2)*CLKS_PER_BIT cycles.
  - The first tx falling edge is at E0+1.
  - busy falls and done rises at E0 + NUM_REGS*(1+(DATA_W+2)*CLKS_PER_BIT).
- start while busy=1 is ignored; it is neither queued nor allowed to restart the sequence.
- Bank writes during transmission:
  - A byte already captured in LOAD is unaffected.
  - Later entries are read at their own LOAD cycle, so the new value is sent.
- The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps; it is cleared on entry to START.
- The bit index counts 0..DATA_W-1.
- rd_addr never exceeds NUM_REGS-1 and returns to 0 only on the next accepted start.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, LOAD, START, DATA, STOP};
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - a frame-length function (DATA_W+2)*CLKS_PER_BIT.
- One natural sub-module: bit_timer.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear and enable.
  - Output: a one-cycle tick on the last cycle of each bit period.
- The FSM, shift register and address counter stay in reg_bank_tx.

Test Plan (CLKS_PER_BIT=4, DATA_W=8, NUM_REGS=4; frame = 41 cycles):
- Bank = {0x55, 0xA3, 0x00, 0xFF}; pulse start at E0.
  - Sampling tx mid-bit decodes 0x55, 0xA3, 0x00, 0xFF in order.
  - rd_addr steps 0,1,2,3.
  - done is high for exactly 1 cycle after E0+164; busy falls at the same edge.
- After reset, with no start for 100 cycles: tx=1, busy=0, done=0, rd_addr=0 throughout.
- start re-pulsed at E0+10 and again at E0+80 during a dump: only one 4-byte sequence; done pulses once at E0+164.
- Bank entry 2 rewritten to 0x3C at E0+30 (before its LOAD at E0+82): frame 2 carries 0x3C and frame 0 is unchanged.
- RESET_N driven low at E0+20, mid-data-bit: tx=1 immediately, busy=0, rd_addr=0.
  - After release, a new start produces a clean full sequence.
- start held high continuously for 300 cycles: exactly two back-to-back dumps, each accepted in IDLE, with done pulsing twice.

Source files
------------

// File: rtl/reg_bank_tx_pkg.sv
// Shared types and constants for the register-bank serial read-out.
package reg_bank_tx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Bit-time cycles in one frame, excluding the single LOAD cycle.
   function automatic int unsigned frame_len(input int unsigned data_w,
                                             input int unsigned clks_per_bit);
      return (data_w + 2) * clks_per_bit;
   endfunction

endpackage

// File: rtl/reg_bank_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the last cycle of each period.
module reg_bank_tx_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i)
         cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tick_o = enable_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/reg_bank_tx.sv
// Walks the register bank and serialises each entry as an 8N1-style frame.
//
//   state | meaning
//   IDLE  | line idle high, waiting for start
//   LOAD  | one cycle: capture rd_data for the current address
//   START | start bit (low) for one bit period
//   DATA  | DATA_W data bits, LSB first
//   STOP  | stop bit (high); then next address or finish
module reg_bank_tx
   import reg_bank_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned NUM_REGS     = 4,
   parameter int unsigned ADDR_W       = 2,
   parameter int unsigned DATA_W       = 8
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] cur_byte
);

   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);

   logic rst_meta_q, rst_sync_q;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] cur_byte_q, cur_byte_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic timer_clear, timer_en, bit_tick;

   // Assertion reaches every flop at once; release is retimed to CLOCK_50.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   assign timer_clear = (state_q == IDLE) || (state_q == LOAD);
   assign timer_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

   reg_bank_tx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i    (CLOCK_50),
      .rst_n_i  (rst_sync_q),
      .clear_i  (timer_clear),
      .enable_i (timer_en),
      .tick_o   (bit_tick)
   );

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      shift_d    = shift_q;
      cur_byte_d = cur_byte_q;
      bit_idx_d  = bit_idx_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = IDLE_LEVEL;
            if (start) begin
               state_d   = LOAD;
               busy_d    = 1'b1;
               rd_addr_d = '0;
            end
         end
         LOAD: begin
            shift_d    = rd_data;
            cur_byte_d = rd_data;
            bit_idx_d  = '0;
            tx_d       = START_BIT;
            state_d    = START;
         end
         START: begin
            if (bit_tick) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == LAST_IDX) begin
                  tx_d    = STOP_BIT;
                  state_d = STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         STOP: begin
            // tx is left high, so LOAD stretches the stop bit by one cycle.
            if (bit_tick) begin
               if (rd_addr_q == LAST_ADDR) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
                  state_d   = LOAD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         shift_q    <= '0;
         cur_byte_q <= '0;
         bit_idx_q  <= '0;
         tx_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         shift_q    <= shift_d;
         cur_byte_q <= cur_byte_d;
         bit_idx_q  <= bit_idx_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rd_addr  = rd_addr_q;
   assign tx       = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cur_byte = cur_byte_q;

endmodule
